// File: rtl/mem_arbiter_if.sv
// Request/grant/return signals of the three memory requesters plus the shared RAM port.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  logic              dm_req;
  logic [3:0]        dm_wen;
  logic [31:0]       dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [31:0]       dm_rdata;

  logic              dbg_req;
  logic [31:0]       dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;

  logic              ram_en;
  logic [3:0]        ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata,
           dbg_req, dbg_addr, ram_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           dbg_gnt, dbg_rvalid, dbg_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wen, dm_addr, dm_wdata,
           dbg_req, dbg_addr, ram_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           dbg_gnt, dbg_rvalid, dbg_rdata,
           ram_en, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Unified single-port RAM arbiter: fetch and MEM share round-robin, display is
// lowest priority with an aging counter that eventually forces its grant.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DBG_WAIT = 8
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG} owner_t;

  localparam logic [7:0] WAIT_LIM = 8'(DBG_WAIT);

  logic        rr, rr_nxt;
  logic [7:0]  dbg_cnt, dbg_cnt_nxt;
  owner_t      ret_owner, ret_owner_nxt;
  logic [31:0] hold_if, hold_dm, hold_dbg;
  logic        gnt_if, gnt_dm, gnt_dbg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr        <= 1'b0;
      dbg_cnt   <= '0;
      ret_owner <= OWN_NONE;
      hold_if   <= '0;
      hold_dm   <= '0;
      hold_dbg  <= '0;
    end else begin
      rr        <= rr_nxt;
      dbg_cnt   <= dbg_cnt_nxt;
      ret_owner <= ret_owner_nxt;
      if (ret_owner == OWN_IF)  hold_if  <= bus.ram_rdata;
      if (ret_owner == OWN_DM)  hold_dm  <= bus.ram_rdata;
      if (ret_owner == OWN_DBG) hold_dbg <= bus.ram_rdata;
    end
  end

  // Grants are gated by resetn so the RAM port stays idle while reset is held.
  always_comb begin
    gnt_if  = 1'b0;
    gnt_dm  = 1'b0;
    gnt_dbg = 1'b0;
    if (resetn) begin
      if (bus.dbg_req && dbg_cnt == WAIT_LIM) begin
        gnt_dbg = 1'b1;
      end else if (bus.if_req && !bus.dm_req) begin
        gnt_if = 1'b1;
      end else if (!bus.if_req && bus.dm_req) begin
        gnt_dm = 1'b1;
      end else if (bus.if_req && bus.dm_req) begin
        gnt_if = !rr;
        gnt_dm = rr;
      end else if (bus.dbg_req) begin
        gnt_dbg = 1'b1;
      end
    end
  end

  always_comb begin
    bus.ram_en    = gnt_if | gnt_dm | gnt_dbg;
    bus.ram_wen   = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (gnt_if) begin
      bus.ram_addr = bus.if_addr[ADDR_W+1:2];
    end else if (gnt_dm) begin
      bus.ram_addr  = bus.dm_addr[ADDR_W+1:2];
      bus.ram_wen   = bus.dm_wen;
      bus.ram_wdata = bus.dm_wdata;
    end else if (gnt_dbg) begin
      bus.ram_addr = bus.dbg_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    rr_nxt        = rr;
    dbg_cnt_nxt   = dbg_cnt;
    ret_owner_nxt = OWN_NONE;

    if (gnt_dm)      rr_nxt = 1'b0;
    else if (gnt_if) rr_nxt = 1'b1;

    if (gnt_dbg || !bus.dbg_req) dbg_cnt_nxt = '0;
    else if (dbg_cnt < WAIT_LIM) dbg_cnt_nxt = dbg_cnt + 8'd1;

    if (gnt_if)                            ret_owner_nxt = OWN_IF;
    else if (gnt_dm && bus.dm_wen == '0)   ret_owner_nxt = OWN_DM;
    else if (gnt_dbg)                      ret_owner_nxt = OWN_DBG;
  end

  always_comb begin
    bus.if_gnt     = gnt_if;
    bus.dm_gnt     = gnt_dm;
    bus.dbg_gnt    = gnt_dbg;
    bus.if_rvalid  = (ret_owner == OWN_IF);
    bus.dm_rvalid  = (ret_owner == OWN_DM);
    bus.dbg_rvalid = (ret_owner == OWN_DBG);
    bus.if_rdata   = (ret_owner == OWN_IF)  ? bus.ram_rdata : hold_if;
    bus.dm_rdata   = (ret_owner == OWN_DM)  ? bus.ram_rdata : hold_dm;
    bus.dbg_rdata  = (ret_owner == OWN_DBG) ? bus.ram_rdata : hold_dbg;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-enabled synchronous RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:255];
  logic [31:0] ram_q;
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  mem_arbiter_if #(.ADDR_W(8)) bus ();

  mem_arbiter #(.ADDR_W(8), .DBG_WAIT(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.ram_rdata = ram_q;

  // Registered-read RAM; pre_* lets the bench load words while the port is idle.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.ram_en) begin
      if (bus.ram_wen == 4'b0000) begin
        ram_q <= mem[bus.ram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_wen[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    cyc();
    pre_en   = 1'b0;
  endtask

  task automatic idle_reqs();
    bus.if_req  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.dbg_req = 1'b0;
    bus.dm_wen  = 4'b0000;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dbg_req = 1'b1;
    bus.if_addr = 32'h0; bus.dm_addr = 32'h4; bus.dbg_addr = 32'h8;
    bus.dm_wen = 4'b0000; bus.dm_wdata = 32'h0;
    repeat (3) cyc();
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.dbg_gnt} !== 3'b000) begin
      errors++; $display("FAIL reset_gnt got %b want 000", {bus.if_gnt, bus.dm_gnt, bus.dbg_gnt}); end
    checks++; if (bus.ram_en !== 1'b0 || bus.ram_wen !== 4'b0 || bus.ram_addr !== 8'h0 || bus.ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_ram got en=%b wen=%h addr=%h wdata=%h want all 0",
                         bus.ram_en, bus.ram_wen, bus.ram_addr, bus.ram_wdata); end
    checks++; if ({bus.if_rvalid, bus.dm_rvalid, bus.dbg_rvalid} !== 3'b000) begin
      errors++; $display("FAIL reset_rvalid got %b want 000", {bus.if_rvalid, bus.dm_rvalid, bus.dbg_rvalid}); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h %h %h want 0", bus.if_rdata, bus.dm_rdata, bus.dbg_rdata); end
    resetn = 1'b1;
    #1;
    checks++; if ({bus.if_gnt, bus.dm_gnt, bus.dbg_gnt} !== 3'b100) begin
      errors++; $display("FAIL reset_release_gnt got %b want 100", {bus.if_gnt, bus.dm_gnt, bus.dbg_gnt}); end
    idle_reqs();
    #1;
    checks++; if (bus.ram_en !== 1'b0) begin
      errors++; $display("FAIL idle_ram_en got %b want 0", bus.ram_en); end
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp_if;
    preload(8'd8, 32'hA0A0_0008);
    preload(8'd9, 32'hB0B0_0009);
    bus.if_addr = 32'h20; bus.dm_addr = 32'h24; bus.dm_wen = 4'b0000;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_if = (i % 2 == 0);
      #1;
      checks++; if (bus.if_gnt !== exp_if || bus.dm_gnt !== !exp_if) begin
        errors++; $display("FAIL rr_gnt[%0d] got if=%b dm=%b want if=%b", i, bus.if_gnt, bus.dm_gnt, exp_if); end
      if (i > 0) begin
        if (!exp_if) begin
          checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA0A0_0008 || bus.dm_rvalid !== 1'b0) begin
            errors++; $display("FAIL rr_ret_if[%0d] got v=%b d=%h dmv=%b want 1 a0a00008 0",
                               i, bus.if_rvalid, bus.if_rdata, bus.dm_rvalid); end
        end else begin
          checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hB0B0_0009 || bus.if_rvalid !== 1'b0) begin
            errors++; $display("FAIL rr_ret_dm[%0d] got v=%b d=%h ifv=%b want 1 b0b00009 0",
                               i, bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid); end
        end
      end
      cyc();
    end
    idle_reqs();
    checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'hB0B0_0009 || bus.if_rvalid !== 1'b0) begin
      errors++; $display("FAIL rr_last_ret got v=%b d=%h ifv=%b want 1 b0b00009 0",
                         bus.dm_rvalid, bus.dm_rdata, bus.if_rvalid); end
    cyc();
  endtask

  task automatic test_single_fetch();
    preload(8'd3, 32'h2401_0001);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_000C;
    #1;
    checks++; if (bus.if_gnt !== 1'b1 || bus.ram_addr !== 8'd3 || bus.ram_en !== 1'b1 || bus.ram_wen !== 4'b0) begin
      errors++; $display("FAIL fetch_issue got gnt=%b addr=%h en=%b wen=%h want 1 03 1 0",
                         bus.if_gnt, bus.ram_addr, bus.ram_en, bus.ram_wen); end
    cyc();
    bus.if_req = 1'b0;
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h2401_0001) begin
      errors++; $display("FAIL fetch_ret got v=%b d=%h want 1 24010001", bus.if_rvalid, bus.if_rdata); end
    cyc();
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h2401_0001) begin
      errors++; $display("FAIL fetch_hold got v=%b d=%h want 0 24010001", bus.if_rvalid, bus.if_rdata); end
  endtask

  task automatic test_byte_write();
    preload(8'd5, 32'h1122_3344);
    bus.dm_req = 1'b1; bus.dm_wen = 4'b0010; bus.dm_addr = 32'h14; bus.dm_wdata = 32'hAABB_CCDD;
    #1;
    checks++; if (bus.dm_gnt !== 1'b1 || bus.ram_wen !== 4'b0010 || bus.ram_addr !== 8'd5 || bus.ram_wdata !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL bw_issue got gnt=%b wen=%h addr=%h wd=%h want 1 2 05 aabbccdd",
                         bus.dm_gnt, bus.ram_wen, bus.ram_addr, bus.ram_wdata); end
    cyc();
    bus.dm_wen = 4'b0000; bus.dm_addr = 32'h16;
    #1;
    checks++; if (bus.dm_rvalid !== 1'b0 || bus.dm_gnt !== 1'b1 || bus.ram_wen !== 4'b0 || bus.ram_addr !== 8'd5) begin
      errors++; $display("FAIL bw_read_issue got rv=%b gnt=%b wen=%h addr=%h want 0 1 0 05",
                         bus.dm_rvalid, bus.dm_gnt, bus.ram_wen, bus.ram_addr); end
    cyc();
    idle_reqs();
    checks++; if (bus.dm_rvalid !== 1'b1 || bus.dm_rdata !== 32'h1122_CC44) begin
      errors++; $display("FAIL bw_read_ret got v=%b d=%h want 1 1122cc44", bus.dm_rvalid, bus.dm_rdata); end
    cyc();
  endtask

  task automatic test_anti_starvation();
    logic exp_if;
    preload(8'd16, 32'hDB60_0010);
    bus.if_addr = 32'h0C; bus.dm_addr = 32'h24; bus.dbg_addr = 32'hFFFF_0040;
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dbg_req = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      exp_if = (i % 2 == 1);
      #1;
      if (i < 9) begin
        checks++; if (bus.dbg_gnt !== 1'b0 || bus.if_gnt !== exp_if || bus.dm_gnt !== !exp_if) begin
          errors++; $display("FAIL age_cycle[%0d] got dbg=%b if=%b dm=%b want 0 %b %b",
                             i, bus.dbg_gnt, bus.if_gnt, bus.dm_gnt, exp_if, !exp_if); end
      end else begin
        checks++; if (bus.dbg_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.dm_gnt !== 1'b0 || bus.ram_addr !== 8'd16) begin
          errors++; $display("FAIL age_dbg_gnt got dbg=%b if=%b dm=%b addr=%h want 1 0 0 10",
                             bus.dbg_gnt, bus.if_gnt, bus.dm_gnt, bus.ram_addr); end
      end
      cyc();
    end
    #1;
    checks++; if (bus.if_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      errors++; $display("FAIL age_resume_if got if=%b dbg=%b want 1 0", bus.if_gnt, bus.dbg_gnt); end
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'hDB60_0010) begin
      errors++; $display("FAIL age_dbg_ret got v=%b d=%h want 1 db600010", bus.dbg_rvalid, bus.dbg_rdata); end
    cyc();
    #1;
    checks++; if (bus.dm_gnt !== 1'b1 || bus.dbg_gnt !== 1'b0) begin
      errors++; $display("FAIL age_resume_dm got dm=%b dbg=%b want 1 0", bus.dm_gnt, bus.dbg_gnt); end
    cyc();
    idle_reqs();
    cyc();
  endtask

  task automatic test_reset_mid();
    preload(8'd2, 32'hCAFE_0002);
    bus.if_req = 1'b1; bus.if_addr = 32'h08;
    #1;
    checks++; if (bus.if_gnt !== 1'b1) begin
      errors++; $display("FAIL rm_gnt got %b want 1", bus.if_gnt); end
    cyc();
    resetn = 1'b0;
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.dm_addr = 32'h24;
    #1;
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h0) begin
      errors++; $display("FAIL rm_in_reset got v=%b d=%h want 0 0", bus.if_rvalid, bus.if_rdata); end
    resetn = 1'b1;
    #1;
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_gnt !== 1'b1 || bus.dm_gnt !== 1'b0) begin
      errors++; $display("FAIL rm_release got rv=%b if=%b dm=%b want 0 1 0", bus.if_rvalid, bus.if_gnt, bus.dm_gnt); end
    cyc();
    idle_reqs();
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFE_0002) begin
      errors++; $display("FAIL rm_after got v=%b d=%h want 1 cafe0002", bus.if_rvalid, bus.if_rdata); end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    pre_en = 1'b0; pre_addr = '0; pre_data = '0; ram_q = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_round_robin();
    test_single_fetch();
    test_byte_write();
    test_anti_starvation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
